// File: rtl/tt_access_ctrl.sv
// tt_access_ctrl: round-robin A/B front end for a 2**N x W table.
// Optional zero sweep after reset and on clr is enabled by TT_CLEAR_EN.
module tt_access_ctrl #(
  parameter int N = 12,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [N-1:0] a_addr,
  input  logic [W-1:0] a_wdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [N-1:0] b_addr,
  input  logic [W-1:0] b_wdata,
  output logic         a_gnt,
  output logic         b_gnt,
  output logic         a_rvalid,
  output logic         b_rvalid,
  output logic [W-1:0] a_rdata,
  output logic [W-1:0] b_rdata,
  output logic         tbl_rd_req,
  output logic         tbl_wr_req,
  output logic [N-1:0] tbl_rd_addr,
  output logic [N-1:0] tbl_wr_addr,
  output logic [W-1:0] tbl_wr_data,
  input  logic [W-1:0] tbl_rd_data,
  output logic         busy
);

  logic         in_clr;
  logic [N-1:0] clr_addr;

`ifdef TT_CLEAR_EN
  typedef enum logic {
    S_RUN,
    S_CLEAR
  } state_t;

  state_t       state, state_nx;
  logic [N-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt wraps to 0 on the last sweep address
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      S_CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == '1)
          state_nx = S_RUN;
      end
      S_RUN: begin
        if (clr) begin
          state_nx = S_CLEAR;
          cnt_nx   = '0;
        end
      end
      default: ;
    endcase
  end

  assign in_clr   = (state == S_CLEAR);
  assign clr_addr = cnt;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign in_clr     = 1'b0;
  assign clr_addr   = '0;
`endif

  logic prio_a;
  logic run_ok;
  logic rd_b;
  logic rv2;
  logic rv2_b;

  assign run_ok = ~rst & ~in_clr;
  assign a_gnt  = run_ok & a_req & (~b_req | prio_a);
  assign b_gnt  = run_ok & b_req & (~a_req | ~prio_a);
  assign busy   = in_clr;

  logic         rd_nx;
  logic         wr_nx;
  logic         rd_b_nx;
  logic [N-1:0] rd_addr_nx;
  logic [N-1:0] wr_addr_nx;
  logic [W-1:0] wr_data_nx;

  always_comb begin
    rd_nx      = 1'b0;
    wr_nx      = 1'b0;
    rd_b_nx    = rd_b;
    rd_addr_nx = tbl_rd_addr;
    wr_addr_nx = tbl_wr_addr;
    wr_data_nx = tbl_wr_data;
    unique case (1'b1)
      a_gnt: begin
        wr_nx      = a_we;
        rd_nx      = ~a_we;
        rd_b_nx    = 1'b0;
        rd_addr_nx = a_addr;
        wr_addr_nx = a_addr;
        wr_data_nx = a_wdata;
      end
      b_gnt: begin
        wr_nx      = b_we;
        rd_nx      = ~b_we;
        rd_b_nx    = 1'b1;
        rd_addr_nx = b_addr;
        wr_addr_nx = b_addr;
        wr_data_nx = b_wdata;
      end
      in_clr: begin
        wr_nx      = 1'b1;
        wr_addr_nx = clr_addr;
        wr_data_nx = '0;
      end
      default: ;
    endcase
  end

  // tbl_rd_req is read-pipe stage 1; rv2 lines up with tbl_rd_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_rd_req  <= 1'b0;
      tbl_wr_req  <= 1'b0;
      tbl_rd_addr <= '0;
      tbl_wr_addr <= '0;
      tbl_wr_data <= '0;
      rd_b        <= 1'b0;
      rv2         <= 1'b0;
      rv2_b       <= 1'b0;
      prio_a      <= 1'b1;
    end else begin
      tbl_rd_req  <= rd_nx;
      tbl_wr_req  <= wr_nx;
      tbl_rd_addr <= rd_addr_nx;
      tbl_wr_addr <= wr_addr_nx;
      tbl_wr_data <= wr_data_nx;
      rd_b        <= rd_b_nx;
      rv2         <= tbl_rd_req;
      rv2_b       <= rd_b;
      if (a_gnt)
        prio_a <= 1'b0;
      else if (b_gnt)
        prio_a <= 1'b1;
    end
  end

  assign a_rvalid = rv2 & ~rv2_b;
  assign b_rvalid = rv2 & rv2_b;
  assign a_rdata  = tbl_rd_data;
  assign b_rdata  = tbl_rd_data;

endmodule

// File: tb/tb_tt_access_ctrl.sv
// tb_tt_access_ctrl: scoreboard bench for tt_access_ctrl (N=4, W=16).
// Works with or without TT_CLEAR_EN defined globally.
module tb_tt_access_ctrl;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         a_req = 1'b0, a_we = 1'b0;
  logic [N-1:0] a_addr = '0;
  logic [W-1:0] a_wdata = '0;
  logic         b_req = 1'b0, b_we = 1'b0;
  logic [N-1:0] b_addr = '0;
  logic [W-1:0] b_wdata = '0;
  logic         a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [W-1:0] a_rdata, b_rdata;
  logic         tbl_rd_req, tbl_wr_req;
  logic [N-1:0] tbl_rd_addr, tbl_wr_addr;
  logic [W-1:0] tbl_wr_data;
  logic [W-1:0] tbl_rd_data = '0;
  logic         busy;

  tt_access_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
    .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] tmem [2**N];
  logic [W-1:0] ref_mem [2**N];

  always @(posedge clk)
    if (tbl_rd_req) tbl_rd_data <= tmem[tbl_rd_addr];
  always @(negedge clk)
    if (tbl_wr_req) tmem[tbl_wr_addr] <= tbl_wr_data;

  typedef struct {
    logic [W-1:0] d;
    int           t;
  } rexp_t;
  typedef struct {
    logic [N-1:0] a;
    logic [W-1:0] d;
    int           t;
  } cexp_t;

  rexp_t qa[$], qb[$];
  cexp_t qw[$], qr[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [N-1:0] ad,
                          input logic [W-1:0] d, input logic is_b);
    cexp_t c;
    rexp_t r;
    c.a = ad;
    c.d = d;
    c.t = cyc + 1;
    if (we) begin
      ref_mem[ad] = d;
      qw.push_back(c);
    end else begin
      c.d = '0;
      qr.push_back(c);
      r.d = ref_mem[ad];
      r.t = cyc + 2;
      if (is_b) qb.push_back(r);
      else qa.push_back(r);
    end
  endtask

  task automatic drv(input logic ar, input logic aw, input logic [N-1:0] aa,
                     input logic [W-1:0] ad, input logic br, input logic bw,
                     input logic [N-1:0] ba, input logic [W-1:0] bd,
                     input logic ega, input logic egb);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    chk("a_gnt", a_gnt, ega);
    chk("b_gnt", b_gnt, egb);
    if (ega) push_cmd(aw, aa, ad, 1'b0);
    if (egb) push_cmd(bw, ba, bd, 1'b1);
  endtask

  task automatic step(input logic ar, input logic aw, input logic [N-1:0] aa,
                      input logic [W-1:0] ad, input logic br, input logic bw,
                      input logic [N-1:0] ba, input logic [W-1:0] bd,
                      input logic ega, input logic egb);
    @(posedge clk);
    #1;
    drv(ar, aw, aa, ad, br, bw, ba, bd, ega, egb);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef TT_CLEAR_EN
  // first CLEAR cycle in progress; A read of addr 5 is held off
  task automatic sweep();
    cexp_t c;
    for (int k = 0; k < 2**N; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      clr = (k == 5);
      drv(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      chk("busy_clear", busy, 1);
      c.a = k[N-1:0];
      c.d = '0;
      c.t = cyc + 1;
      qw.push_back(c);
      ref_mem[k] = '0;
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    drv(1, 0, 5, 0, 0, 0, 0, 0, 1, 0);
    chk("busy_run", busy, 0);
  endtask
`endif

  task automatic after_reset();
`ifdef TT_CLEAR_EN
    sweep();
`else
    chk("busy_run", busy, 0);
    drv(1, 0, 5, 0, 0, 0, 0, 0, 1, 0);
`endif
  endtask

  rexp_t re;
  cexp_t ce;
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (qa.size() == 0) chk("a_rvalid_unexpected", 1, 0);
      else begin
        re = qa.pop_front();
        chk("a_rdata", a_rdata, re.d);
        chk("a_rvalid_cycle", cyc, re.t);
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) chk("b_rvalid_unexpected", 1, 0);
      else begin
        re = qb.pop_front();
        chk("b_rdata", b_rdata, re.d);
        chk("b_rvalid_cycle", cyc, re.t);
      end
    end
    if (tbl_wr_req) begin
      if (qw.size() == 0) chk("tbl_wr_unexpected", 1, 0);
      else begin
        ce = qw.pop_front();
        chk("tbl_wr_addr", tbl_wr_addr, ce.a);
        chk("tbl_wr_data", tbl_wr_data, ce.d);
        chk("tbl_wr_cycle", cyc, ce.t);
      end
    end
    if (tbl_rd_req) begin
      if (qr.size() == 0) chk("tbl_rd_unexpected", 1, 0);
      else begin
        ce = qr.pop_front();
        chk("tbl_rd_addr", tbl_rd_addr, ce.a);
        chk("tbl_rd_cycle", cyc, ce.t);
      end
    end
  end

  function automatic logic [63:0] outs();
    return {34'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, tbl_rd_req,
            tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data};
  endfunction

  initial begin
    for (int i = 0; i < 2**N; i++) begin
      ref_mem[i] = 16'h1000 + 16'(i);
      tmem[i] <= 16'h1000 + 16'(i);
    end
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_req = 1'b1;
    #1;
    chk("reset_outputs", outs(), 0);
`ifndef TT_CLEAR_EN
    chk("reset_busy", busy, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    after_reset();

    // write then read-after-write on A
    step(1, 1, 3, 16'h00AB, 0, 0, 0, 0, 1, 0);
    step(1, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();

    // B write then read
    step(0, 0, 0, 0, 1, 1, 9, 16'h1234, 0, 1);
    step(0, 0, 0, 0, 1, 0, 9, 0, 0, 1);
    idle();

    // both requesting: A first since B was granted last
    for (int i = 0; i < 6; i++)
      step(1, 0, 1, 0, 1, 0, 2, 0, (i % 2) == 0, (i % 2) == 1);
    idle();
    idle();
    idle();

    // clr one cycle after a B read grant
    step(0, 0, 0, 0, 1, 0, 7, 0, 0, 1);
    @(posedge clk);
    #1;
    clr = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("busy_clr_cycle", busy, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
`ifdef TT_CLEAR_EN
    sweep();
`else
    chk("busy_after_clr", busy, 0);
    drv(1, 0, 6, 0, 0, 0, 0, 0, 1, 0);
`endif
    idle();
    idle();
    idle();

    // reset in the cycle after an A read grant
    step(1, 0, 4, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midread_reset_outputs", outs(), 0);
    qa.delete();
    qb.delete();
    qr.delete();
    qw.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    after_reset();
    repeat (4) idle();

    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
    chk("pending_rd", qr.size(), 0);
    chk("pending_wr", qw.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_access_ctrl.md
TT_ACCESS_CTRL -- requirements
Module: tt_access_ctrl

Interface
REQ-001 Parameter N, default 12: table address width; the table holds 2**N entries.
REQ-002 Parameter W, default 16: table data width.
REQ-003 clk  input  1  sole clock; all state changes on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  one-cycle pulse; restarts the clear sweep (REQ-016).
REQ-006 a_req/b_req  input  1  requester A/B access request, held until granted.
REQ-007 a_we/b_we  input  1  1=write, 0=read; qualified by req.
REQ-008 a_addr/b_addr  input  N  requester address.
REQ-009 a_wdata/b_wdata  input  W  requester write data.
REQ-010 a_gnt/b_gnt  output  1  combinational grant; request is accepted this cycle.
REQ-011 a_rvalid/b_rvalid  output  1  read data valid to requester A/B.
REQ-012 a_rdata/b_rdata  output  W  read data; equals tbl_rd_data, meaningful only while rvalid=1.
REQ-013 tbl_rd_req, tbl_wr_req  output  1  registered table read/write strobes.
REQ-014 tbl_rd_addr, tbl_wr_addr  output  N; tbl_wr_data  output  W: registered table command fields.
REQ-015 tbl_rd_data  input  W, from the table, registered inside the table one cycle after tbl_rd_req; busy  output  1, high during the clear sweep.

Function
REQ-016 States: CLEAR, RUN. CLEAR: counter runs 0..2**N-1, one address per cycle; tbl_wr_req=1, tbl_wr_data=0; busy=1; gnts=0. After address 2**N-1 is issued, the FSM enters RUN.
REQ-017 RUN: a grant is issued only when the corresponding req=1; at most one grant per cycle.
REQ-018 Arbitration: sole requester wins; if both request, the requester not granted last wins (round robin); after reset A has priority.
REQ-019 Granted request at cycle T: tbl_* strobe, address and data are driven in cycle T+1; both strobes are 0 in any cycle without a grant at T.
REQ-020 Read granted at T: the owner's rvalid=1 exactly in cycle T+2, one cycle only; the other requester's rvalid stays 0.
REQ-021 Back-to-back grants, one per cycle, are sustained; reads pipeline with no bubbles.
REQ-022 Write at T followed by read of the same address at T+1 returns the new data, because the table writes on the negedge of cycle T+1.
REQ-023 clr in RUN: enters CLEAR at the next cycle with counter=0; reads granted before clr still deliver rvalid. clr in CLEAR is ignored.
REQ-024 Requests in CLEAR are held off with gnt=0 and are not lost; they are served in RUN.

Reset
REQ-025 rst=1 asynchronously clears: all tbl_* outputs to 0, gnts 0, rvalids 0, read pipeline flushed, round-robin pointer to favour A, counter 0.
REQ-026 After rst deassertion, the FSM enters CLEAR when TT_CLEAR_EN is defined, otherwise RUN; busy=1 only in CLEAR.
REQ-027 rst mid-sweep or mid-read drops all in-flight reads; no rvalid is emitted for them.

Configuration
REQ-028 Macro TT_CLEAR_EN defined: CLEAR state, counter and clr behaviour are present.
REQ-029 TT_CLEAR_EN undefined: the FSM is permanently in RUN, clr is ignored, busy is tied 0, and the counter is removed.

Verification
REQ-030 N=4, TT_CLEAR_EN defined, reset released -> busy=1 for 16 cycles; tbl_wr_addr 0..15 with data 0; then busy=0.
REQ-031 A writes addr 3 data 0x00AB at T; A reads addr 3 at T+1 -> a_rvalid at T+3, a_rdata=0x00AB.
REQ-032 a_req and b_req held high (reads, addr 1 and 2) for 6 cycles -> grants alternate A,B,A,B,A,B; rvalids alternate 2 cycles later.
REQ-033 clr pulsed one cycle after a B read grant -> b_rvalid still arrives 2 cycles after the grant; busy rises next cycle; sweep restarts at addr 0.
REQ-034 rst asserted in the cycle after an A read grant -> no a_rvalid; all outputs 0 immediately.
REQ-035 TT_CLEAR_EN undefined, A read granted in the first cycle after reset -> busy=0 throughout; a_rvalid 2 cycles later.
